// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into big-endian 32-bit words and writes
// them sequentially into the instruction RAM, holding the CPU until the image
// is complete. Stream = 16-bit word count (MSB first) followed by the words.
module imem_loader #(
   parameter int DEPTH   = 256,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   localparam int WI = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
   localparam logic [16:0]   DEPTH_W = 17'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_LO, S_BYTE, S_WRITE, S_RUN, S_ERR
   } state_t;

   state_t          state_reg;
   logic [15:0]     count_reg;
   logic [1:0]      byte_idx_reg;
   logic [WI-1:0]   word_idx_reg;
   logic [TW-1:0]   timer_reg;
   logic            in_ready_reg;
   logic            mem_we_reg;
   logic [31:0]     mem_addr_reg;
   logic [31:0]     mem_wdata_reg;
   logic            cpu_hold_reg;
   logic            load_done_reg;
   logic            load_err_reg;

   logic            accept;
   logic            timed_out;
   logic [15:0]     count_full;
   logic [WI-1:0]   word_idx_inc;
   logic            last_word;

   // Handshake and helper decodes of the registered state
   assign accept       = in_valid & in_ready_reg;
   assign timed_out    = (timer_reg == T_LAST);
   assign count_full   = {count_reg[15:8], in_data};
   assign word_idx_inc = word_idx_reg + WI'(1);
   assign last_word    = ({{(16-WI){1'b0}}, word_idx_inc} == count_reg);

   // Loader FSM: header parse, word assembly, RAM write and terminal states
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         count_reg     <= '0;
         byte_idx_reg  <= '0;
         word_idx_reg  <= '0;
         timer_reg     <= '0;
         in_ready_reg  <= 1'b1;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         cpu_hold_reg  <= 1'b1;
         load_done_reg <= 1'b0;
         load_err_reg  <= 1'b0;
      end else begin
         mem_we_reg    <= 1'b0;
         load_done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  count_reg[15:8] <= in_data;
                  timer_reg       <= '0;
                  state_reg       <= S_CNT_LO;
               end
            end
            S_CNT_LO: begin
               if (accept) begin
                  count_reg <= count_full;
                  if (count_full == 16'd0 || {1'b0, count_full} > DEPTH_W) begin
                     in_ready_reg <= 1'b0;
                     load_err_reg <= 1'b1;
                     state_reg    <= S_ERR;
                  end else begin
                     byte_idx_reg <= '0;
                     timer_reg    <= '0;
                     state_reg    <= S_BYTE;
                  end
               end else if (timed_out) begin
                  in_ready_reg <= 1'b0;
                  load_err_reg <= 1'b1;
                  state_reg    <= S_ERR;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            S_BYTE: begin
               if (accept) begin
                  mem_wdata_reg <= {mem_wdata_reg[23:0], in_data};
                  timer_reg     <= '0;
                  byte_idx_reg  <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3) begin
                     // Address is captured here so it is stable for the whole write cycle
                     mem_addr_reg <= {{(30-WI){1'b0}}, word_idx_reg, 2'b00};
                     mem_we_reg   <= 1'b1;
                     in_ready_reg <= 1'b0;
                     state_reg    <= S_WRITE;
                  end
               end else if (timed_out) begin
                  in_ready_reg <= 1'b0;
                  load_err_reg <= 1'b1;
                  state_reg    <= S_ERR;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            S_WRITE: begin
               word_idx_reg <= word_idx_inc;
               if (last_word) begin
                  cpu_hold_reg  <= 1'b0;
                  load_done_reg <= 1'b1;
                  state_reg     <= S_RUN;
               end else begin
                  byte_idx_reg <= '0;
                  timer_reg    <= '0;
                  in_ready_reg <= 1'b1;
                  state_reg    <= S_BYTE;
               end
            end
            S_RUN: begin
            end
            S_ERR: begin
            end
            default: begin
               in_ready_reg <= 1'b0;
               load_err_reg <= 1'b1;
               state_reg    <= S_ERR;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign cpu_hold  = cpu_hold_reg;
   assign load_done = load_done_reg;
   assign load_err  = load_err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a reference model turns each byte stream
// into the expected (address, word) writes; a monitor pops and compares them.
module tb_imem_loader;

   typedef logic [7:0] byte_q_t [$];

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_we, cpu_hold, load_done, load_err;
   logic [31:0] mem_addr, mem_wdata;

   int vectors = 0;
   int miscompares = 0;
   int done_count = 0;
   logic prev_hold = 1'b1;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(256), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
      .load_err(load_err)
   );

   // Monitor: pops expected writes and checks handshake/done invariants
   always @(negedge clk) begin
      logic [63:0] e;
      if (reset) begin
         if (mem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_write got addr=%h data=%h required no write", mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({mem_addr, mem_wdata} !== e) begin
                  miscompares++;
                  $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                           mem_addr, mem_wdata, e[63:32], e[31:0]);
               end else begin
                  $display("write addr=%h data=%h ok", mem_addr, mem_wdata);
               end
            end
         end
         if (cpu_hold && !load_err) begin
            vectors++;
            if (in_ready !== !mem_we) begin
               miscompares++;
               $display("FAIL ready_vs_we got in_ready=%b mem_we=%b required in_ready=!mem_we", in_ready, mem_we);
            end
         end
         if (load_done) begin
            done_count++;
            vectors++;
            if (cpu_hold !== 1'b0 || prev_hold !== 1'b1) begin
               miscompares++;
               $display("FAIL done_hold got cpu_hold=%b prev=%b required 0 after 1", cpu_hold, prev_hold);
            end
         end
         prev_hold = cpu_hold;
      end else begin
         prev_hold = 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h required=%h", name, got, want);
      end
   endtask

   // Reference model: header + big-endian words -> expected writes
   function automatic bit model(input byte_q_t b);
      int n;
      n = {b[0], b[1]};
      if (n == 0 || n > 256) return 1'b1;
      for (int i = 0; i < n; i++)
         exp_q.push_back({32'(4 * i), b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
      return 1'b0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_flags", {30'd0, load_done, load_err}, 32'd0);
      exp_q.delete();
      done_count = 0;
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Driver: each byte after a gap (random up to max_gap, or exactly max_gap if fixed)
   task automatic send(input byte_q_t b, input int max_gap, input bit fixed);
      int gap, waited;
      bit acc;
      foreach (b[i]) begin
         gap = fixed ? max_gap : ((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
         if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = b[i];
         waited   = 0;
         forever begin
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
            waited++;
            if (waited > 40) begin
               vectors++;
               miscompares++;
               $display("FAIL accept_timeout byte %0d got no accept required accept", i);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic end_check(input string name, input int exp_done, input bit exp_err,
                            input bit exp_hold, input bit exp_ready);
      repeat (3) @(negedge clk);
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({name, "_done"}, 32'(done_count), 32'(exp_done));
      check({name, "_err"}, 32'(load_err), 32'(exp_err));
      check({name, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
      check({name, "_ready"}, 32'(in_ready), 32'(exp_ready));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t b, b1;
      bit err;
      int n;
      b1 = '{8'h00, 8'h02, 8'h3c, 8'h01, 8'h00, 8'h00, 8'h34, 8'h30, 8'h00, 8'h00};

      // Basic two-word load, back-to-back bytes
      do_reset();
      err = model(b1);
      send(b1, 0, 1'b0);
      end_check("t1", 1, err, 1'b0, 1'b0);

      // N == 0 rejected
      do_reset();
      b = '{8'h00, 8'h00};
      err = model(b);
      send(b, 0, 1'b0);
      end_check("t2", 0, err, 1'b1, 1'b0);

      // N == 257 rejected
      do_reset();
      b = '{8'h01, 8'h01};
      err = model(b);
      send(b, 3, 1'b0);
      end_check("t3a", 0, err, 1'b1, 1'b0);

      // Full-depth load, last write at 0x3FC
      do_reset();
      b = '{8'h01, 8'h00};
      for (int i = 0; i < 1024; i++) b.push_back(8'($urandom));
      err = model(b);
      send(b, 2, 1'b0);
      end_check("t3b", 1, err, 1'b0, 1'b0);

      // Timeout after 16 idle cycles mid-word
      do_reset();
      b = '{8'h00, 8'h01, 8'h3c, 8'h01, 8'h00};
      send(b, 0, 1'b0);
      repeat (15) @(negedge clk);
      check("t4_err_at15", 32'(load_err), 32'd0);
      @(negedge clk);
      check("t4_err_at16", 32'(load_err), 32'd1);
      end_check("t4a", 0, 1'b1, 1'b1, 1'b0);

      // No timeout while idle before the first byte
      do_reset();
      repeat (100) @(negedge clk);
      check("t4b_err", 32'(load_err), 32'd0);
      check("t4b_ready", 32'(in_ready), 32'd1);

      // Gaps of exactly 15 idle cycles between bytes are tolerated
      do_reset();
      b = '{8'h00, 8'h02};
      for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
      err = model(b);
      send(b, 15, 1'b1);
      end_check("t4c", 1, err, 1'b0, 1'b0);

      // Constant byte held valid across the write cycles
      do_reset();
      b = '{8'h00, 8'h03};
      for (int i = 0; i < 12; i++) b.push_back(8'h5a);
      err = model(b);
      send(b, 0, 1'b0);
      end_check("t5", 1, err, 1'b0, 1'b0);

      // Reset mid-load, then replay from scratch
      do_reset();
      b.delete();
      for (int i = 0; i < 6; i++) b.push_back(b1[i]);
      exp_q.push_back({32'h0, 32'h3c010000});
      send(b, 0, 1'b0);
      repeat (2) @(negedge clk);
      check("t6_first_write", 32'(exp_q.size()), 32'd0);
      do_reset();
      err = model(b1);
      send(b1, 0, 1'b0);
      end_check("t6", 1, err, 1'b0, 1'b0);

      // Random loads with random gaps
      for (int t = 0; t < 6; t++) begin
         do_reset();
         n = $urandom_range(24, 1);
         b = '{8'(n >> 8), 8'(n)};
         for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
         err = model(b);
         send(b, 15, 1'b0);
         end_check("t7", 1, err, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
